// File: rtl/pixel_decryptor.sv
// Pixel decryptor: pops one key byte per ciphertext pixel from a small keystream FIFO and emits plaintext.
// Build option: define PIXEL_DECRYPTOR_CHAIN_EN for ciphertext chaining (c_prev seeded from iv).
module pixel_decryptor #(
   parameter int KS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  iv,
   input  logic [15:0] frame_len,
   input  logic [22:0] ks_in,
   input  logic        ks_valid,
   output logic        ks_ready,
   input  logic [7:0]  ct_in,
   input  logic        ct_valid,
   output logic        ct_ready,
   output logic [7:0]  pt_out,
   output logic        pt_valid,
   input  logic        pt_ready,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state_dbg
);

   // Handshake (ks, ct, pt): a beat moves on the rising edge where valid && ready are both high;
   // the producer holds valid and data stable until then, and no ready looks at its own channel's valid.

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int AW = $clog2(KS_DEPTH);

   logic [1:0]    state, state_nx;
   logic [15:0]   remaining;
   logic [7:0]    fifo_mem [KS_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, fifo_count;
   logic          fifo_full, fifo_empty;
   logic          frame_start, ks_push, ct_xfer, pt_xfer;
   logic [7:0]    key, dec;

   assign frame_start = (state == IDLE) && start;
   assign fifo_count  = wr_ptr - rd_ptr;
   assign fifo_full   = (fifo_count == (AW+1)'(KS_DEPTH));
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign ks_ready    = (state == RUN) && !fifo_full;
   assign ct_ready    = (state == RUN) && !fifo_empty && (!pt_valid || pt_ready);
   assign ks_push     = ks_valid && ks_ready;
   assign ct_xfer     = ct_valid && ct_ready;
   assign pt_xfer     = pt_valid && pt_ready;
   assign key         = fifo_mem[rd_ptr[AW-1:0]];
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign state_dbg   = state;

`ifdef PIXEL_DECRYPTOR_CHAIN_EN
   logic [7:0] c_prev;
   logic       unused_bits;
   assign unused_bits = ^ks_in[22:8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              c_prev <= 8'h00;
      else if (frame_start) c_prev <= iv;
      else if (ct_xfer)     c_prev <= ct_in;
   end

   assign dec = (ct_in ^ c_prev) - key;
`else
   logic unused_bits;
   assign unused_bits = ^{iv, ks_in[22:8]};
   assign dec = ct_in - key;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (frame_len == 16'd0) ? DONE : RUN;
         RUN:     if (ct_xfer && (remaining == 16'd1)) state_nx = DRAIN;
         DRAIN:   if (pt_xfer) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= 16'd0;
      end else begin
         state <= state_nx;
         if (frame_start)  remaining <= frame_len;
         else if (ct_xfer) remaining <= remaining - 16'd1;
      end
   end

   // A start flush resets both pointers; stale keys from the last frame are dropped here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (frame_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ks_push) wr_ptr <= wr_ptr + 1'b1;
         if (ct_xfer) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ks_push) fifo_mem[wr_ptr[AW-1:0]] <= ks_in[7:0];
   end

   // A new pixel may load in the same cycle the previous one leaves, giving one pixel per clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pt_out   <= 8'h00;
         pt_valid <= 1'b0;
      end else if (ct_xfer) begin
         pt_out   <= dec;
         pt_valid <= 1'b1;
      end else if (pt_xfer) begin
         pt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_decryptor.sv
// Directed bench for pixel_decryptor; expected pixels follow the PIXEL_DECRYPTOR_CHAIN_EN build setting.
module tb_pixel_decryptor;

   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

`ifdef PIXEL_DECRYPTOR_CHAIN_EN
   localparam logic [7:0] E_SINGLE = 8'h59, E_CH1 = 8'h12, E_CH2 = 8'h26;
   localparam logic [7:0] E_BP0 = 8'h0F, E_BP1 = 8'h2E, E_BP2 = 8'h0D;
   localparam logic [7:0] E_SI1 = 8'h4B, E_SI2 = 8'h2A;
`else
   localparam logic [7:0] E_SINGLE = 8'h23, E_CH1 = 8'h12, E_CH2 = 8'h34;
   localparam logic [7:0] E_BP0 = 8'h0F, E_BP1 = 8'h1E, E_BP2 = 8'h2D;
   localparam logic [7:0] E_SI1 = 8'h4B, E_SI2 = 8'h5A;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  iv = 8'h00;
   logic [15:0] frame_len = 16'd0;
   logic [22:0] ks_in = 23'd0;
   logic        ks_valid = 1'b0;
   logic        ks_ready;
   logic [7:0]  ct_in = 8'h00;
   logic        ct_valid = 1'b0;
   logic        ct_ready;
   logic [7:0]  pt_out;
   logic        pt_valid;
   logic        pt_ready = 1'b0;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   pixel_decryptor #(.KS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .iv(iv), .frame_len(frame_len),
      .ks_in(ks_in), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .ct_in(ct_in), .ct_valid(ct_valid), .ct_ready(ct_ready),
      .pt_out(pt_out), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, simulation stuck");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_frame(input logic [7:0] v, input logic [15:0] len);
      iv = v;
      frame_len = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_ks(input logic [22:0] w);
      int n = 0;
      ks_in = w;
      ks_valid = 1'b1;
      while (!ks_ready && n < 50) begin tick(); n++; end
      n_vec++;
      if (!ks_ready) begin
         n_err++;
         $display("FAIL ks_handshake: ks_ready=%b required 1 within 50 cycles", ks_ready);
      end else tick();
      ks_valid = 1'b0;
   endtask

   task automatic send_ct(input logic [7:0] c);
      int n = 0;
      ct_in = c;
      ct_valid = 1'b1;
      while (!ct_ready && n < 50) begin tick(); n++; end
      n_vec++;
      if (!ct_ready) begin
         n_err++;
         $display("FAIL ct_handshake: ct_ready=%b required 1 within 50 cycles", ct_ready);
      end else tick();
      ct_valid = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      repeat (2) tick();
      n_vec++;
      if ({pt_out, pt_valid, ks_ready, ct_ready, busy, done, state_dbg} !== 15'h0) begin
         n_err++;
         $display("FAIL reset_held: outs=%h required 0000", {pt_out, pt_valid, ks_ready, ct_ready, busy, done, state_dbg});
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if ({pt_out, pt_valid, ks_ready, ct_ready, busy, done, state_dbg} !== 15'h0) begin
         n_err++;
         $display("FAIL reset_release: outs=%h required 0000", {pt_out, pt_valid, ks_ready, ct_ready, busy, done, state_dbg});
      end
   endtask

   task automatic test_single();
      pt_ready = 1'b1;
      begin_frame(8'h5A, 16'd1);
      push_ks(23'h7FFF10);
      send_ct(8'h33);
      n_vec++;
      if ({pt_valid, pt_out, state_dbg} !== {1'b1, E_SINGLE, S_DRAIN}) begin
         n_err++;
         $display("FAIL single_pt: valid/pt/state=%b/%h/%0d required 1/%h/%0d", pt_valid, pt_out, state_dbg, E_SINGLE, S_DRAIN);
      end
      tick();
      n_vec++;
      if ({done, pt_valid, busy} !== 3'b101) begin
         n_err++;
         $display("FAIL single_done: done/pt_valid/busy=%b required 101", {done, pt_valid, busy});
      end
      tick();
      n_vec++;
      if ({done, busy} !== 2'b00) begin
         n_err++;
         $display("FAIL single_idle: done/busy=%b required 00", {done, busy});
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      pt_ready = 1'b0;
      begin_frame(8'h00, 16'd3);
      push_ks({15'h5A5A, 8'h01});
      push_ks({15'h1234, 8'h02});
      push_ks({15'h7FFF, 8'h03});
      push_ks({15'h0F0F, 8'h04});
      n_vec++;
      if (ks_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_fifo_full: ks_ready=%b required 0", ks_ready);
      end
      exp_q = {E_BP0, E_BP1, E_BP2};
      send_ct(8'h10);
      ct_in = 8'h20;
      ct_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({ct_ready, pt_valid, pt_out} !== {1'b0, 1'b1, E_BP0}) begin
            n_err++;
            $display("FAIL bp_stall%0d: ct_ready/pt_valid/pt=%b/%b/%h required 0/1/%h", i, ct_ready, pt_valid, pt_out, E_BP0);
         end
         tick();
      end
      pt_ready = 1'b1;
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({ct_ready, pt_out} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL bp_pix0: ct_ready/pt=%b/%h required 1/%h", ct_ready, pt_out, e);
      end
      tick();
      ct_in = 8'h30;
      e = exp_q.pop_front();
      n_vec++;
      if ({pt_valid, pt_out} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL bp_pix1: pt_valid/pt=%b/%h required 1/%h", pt_valid, pt_out, e);
      end
      tick();
      ct_valid = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if ({pt_valid, pt_out, state_dbg} !== {1'b1, e, S_DRAIN}) begin
         n_err++;
         $display("FAIL bp_pix2: valid/pt/state=%b/%h/%0d required 1/%h/%0d", pt_valid, pt_out, state_dbg, e, S_DRAIN);
      end
      tick();
      n_vec++;
      if ({done, exp_q.size() == 0} !== 2'b11) begin
         n_err++;
         $display("FAIL bp_done: done=%b left=%0d required done=1 left=0", done, exp_q.size());
      end
      tick();
   endtask

   task automatic test_wrap();
      begin_frame(8'h00, 16'd1);
      push_ks(23'h000001);
      send_ct(8'h00);
      n_vec++;
      if (pt_out !== 8'hFF) begin
         n_err++;
         $display("FAIL wrap_pt: pt=%h required ff", pt_out);
      end
      tick();
      n_vec++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_done: done=%b required 1", done);
      end
      tick();
   endtask

   task automatic test_chain();
      begin_frame(8'h00, 16'd2);
      push_ks(23'h000000);
      push_ks(23'h000000);
      send_ct(8'h12);
      n_vec++;
      if (pt_out !== E_CH1) begin
         n_err++;
         $display("FAIL chain_pix0: pt=%h required %h", pt_out, E_CH1);
      end
      send_ct(8'h34);
      n_vec++;
      if ({pt_valid, pt_out, state_dbg} !== {1'b1, E_CH2, S_DRAIN}) begin
         n_err++;
         $display("FAIL chain_pix1: valid/pt/state=%b/%h/%0d required 1/%h/%0d", pt_valid, pt_out, state_dbg, E_CH2, S_DRAIN);
      end
      tick();
      n_vec++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL chain_done: done=%b required 1", done);
      end
      tick();
   endtask

   task automatic test_zero_len();
      begin_frame(8'h00, 16'd0);
      n_vec++;
      if ({busy, done, ks_ready, ct_ready, state_dbg} !== {4'b1100, S_DONE}) begin
         n_err++;
         $display("FAIL zero_len_done: busy/done/ks_rdy/ct_rdy=%b state=%0d required 1100 state=%0d", {busy, done, ks_ready, ct_ready}, state_dbg, S_DONE);
      end
      tick();
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL zero_len_idle: busy/done=%b required 00", {busy, done});
      end
   endtask

   task automatic test_start_ignored();
      begin_frame(8'h00, 16'd2);
      iv = 8'hFF;
      frame_len = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (state_dbg !== S_RUN) begin
         n_err++;
         $display("FAIL start_ignored_state: state=%0d required %0d", state_dbg, S_RUN);
      end
      push_ks(23'h000005);
      push_ks(23'h000006);
      send_ct(8'h50);
      n_vec++;
      if ({pt_out, state_dbg} !== {E_SI1, S_RUN}) begin
         n_err++;
         $display("FAIL start_ignored_pix0: pt/state=%h/%0d required %h/%0d", pt_out, state_dbg, E_SI1, S_RUN);
      end
      send_ct(8'h60);
      n_vec++;
      if ({pt_out, state_dbg} !== {E_SI2, S_DRAIN}) begin
         n_err++;
         $display("FAIL start_ignored_pix1: pt/state=%h/%0d required %h/%0d", pt_out, state_dbg, E_SI2, S_DRAIN);
      end
      tick();
      n_vec++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL start_ignored_done: done=%b required 1", done);
      end
      tick();
   endtask

   task automatic test_rst_midframe();
      begin_frame(8'h00, 16'd4);
      for (int i = 0; i < 4; i++) push_ks(23'h000000);
      send_ct(8'h11);
      send_ct(8'h22);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({pt_out, pt_valid, ks_ready, ct_ready, busy, done, state_dbg} !== 15'h0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: outs=%h required 0000", {pt_out, pt_valid, ks_ready, ct_ready, busy, done, state_dbg});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_nodone%0d: busy/done=%b required 00", i, {busy, done});
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_wrap();
      test_chain();
      test_zero_len();
      test_start_ignored();
      test_rst_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
